mux16_rr_arbiter: RTL and testbench
===================================

Name: mux16_rr_arbiter

Overview:
Round-robin arbiter that shares one 16-to-1 mux among 16 requesters. Requester i owns mux data input i.
The block produces the mux's 4-bit select, a one-hot grant vector and a valid strobe.
Each grant is held for at most BURST cycles. The pointer then advances so that no requester starves.
It sits directly in front of the 16:1 mux and drives its select bus.

Parameters:
BURST, 4, maximum consecutive cycles one grant is held; legal range 1..16
CNT_W, 4, width of the internal burst counter; must satisfy 2^CNT_W >= BURST

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  synchronous, active-high reset
req  input  16  request vector; bit i = requester i wants mux input i
S16  output  4  mux select, registered; index of the current grantee
gnt  output  16  one-hot grant, registered; gnt[S16] = 1 when valid = 1, otherwise all zeros
valid  output  1  registered; high while a grant is active

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset (rst = 1 at an edge):
  - state <= IDLE, ptr <= 0, cnt <= 0.
  - Outputs: S16 = 0, gnt = 16'h0000, valid = 0.
  - rst has priority over every other condition, including an active grant (reset mid-burst).
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - ptr (4 bits): highest-priority index for the next arbitration.
  - cnt (CNT_W bits): cycles already spent in the current grant.
- IDLE:
  - If req == 0: remain in IDLE. Outputs stay at S16 unchanged, gnt = 0, valid = 0.
  - Else: select the first set bit of req, searching from ptr upward with modulo-16 wrap (ptr, ptr+1, ..., 15, 0, ..., ptr-1). At the edge, S16 <= winner, gnt <= one-hot(winner), valid <= 1, cnt <= 0, state <= GRANT.
  - Latency: a request sampled at edge k is visible on gnt/S16 after edge k (1 cycle).
- GRANT, evaluated at each edge (release condition = req[S16] == 0 OR cnt == BURST-1):
  - If the release condition holds: state <= IDLE, gnt <= 0, valid <= 1'b0, ptr <= S16 + 1 (4-bit wrap, so 15 -> 0), cnt <= 0. S16 holds its last value.
  - Else: cnt <= cnt + 1; S16, gnt and valid are unchanged.
- Consequences of the release rule:
  - A grant lasts min(BURST, cycles req[S16] stays high) cycles.
  - Every release is followed by exactly one IDLE cycle (valid = 0) before the next grant. This bubble is intentional; it guarantees the mux select settles.
- Changes to req bits other than req[S16] during GRANT are ignored until the next IDLE cycle.
- BURST = 1: cnt == 0 == BURST-1 on the first GRANT edge, so every grant is exactly 1 cycle.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt != 0 exactly when valid = 1.
  - When valid = 1, gnt == (16'b1 << S16).

Optional Feature:
Macro MUX16_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit), listed after req.
  - While in GRANT with lock = 1, the cnt == BURST-1 term of the release condition is masked. The grant then persists for as long as req[S16] stays high.
  - cnt saturates at BURST-1 and does not wrap.
  - lock is ignored in IDLE.
- Not defined: no lock port; behaviour is exactly as above.

Test Plan:
- Reset: assert rst for 2 cycles with req = 16'hFFFF -> S16 = 0, gnt = 16'h0000, valid = 0 throughout. Release rst -> first grant is to index 0 one cycle later.
- Single requester: req = 16'h0008 held for 12 cycles, BURST = 4 -> S16 = 3, gnt = 16'h0008. Pattern is valid 4 cycles, gap 1 cycle, repeating (4 on / 1 off).
- Full round robin: req = 16'hFFFF -> S16 sequence 0, 1, 2, ..., 15, 0. Each grant is held 4 cycles with a 1-cycle gap; wrap 15 -> 0 is checked.
- Wrap and skip: bring ptr to 15 (grant index 14 and release), then req = 16'h8001 -> grant 15 first, then 0. With req = 16'h0101 and ptr = 9 -> grant 0, then 8.
- Early release and reset mid-grant:
  - req = 16'h0020 for 2 cycles only -> valid high for exactly 2 cycles, ptr -> 6.
  - Assert rst during cycle 2 of a grant -> gnt = 0 and valid = 0 after that edge, and ptr = 0.
- With MUX16_ARB_LOCK_EN: req = 16'h0004, lock = 1 for 10 cycles -> valid high for 10 consecutive cycles. Deassert lock while req is still high -> release when cnt is at BURST-1, i.e. on the next edge.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select, one-hot grant and valid of a shared 16:1 mux.
// Optional feature macro MUX16_ARB_LOCK_EN: adds a lock input that holds a grant past BURST.
module mux16_rr_arbiter #(
    parameter int BURST = 4,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
`ifdef MUX16_ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic [3:0]  S16,
    output logic [15:0] gnt,
    output logic        valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    state_t           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       s16_q, s16_d;
    logic [15:0]      gnt_q, gnt_d;
    logic             valid_q, valid_d;

    logic [3:0]       winner;
    logic             any_req;
    logic             burst_done;
    logic             release_grant;

    // First requester at or after ptr, wrapping modulo 16.
    always_comb begin
        winner  = ptr_q;
        any_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!any_req && req[ptr_q + 4'(i)]) begin
                winner  = ptr_q + 4'(i);
                any_req = 1'b1;
            end
        end
    end

`ifdef MUX16_ARB_LOCK_EN
    assign burst_done = (cnt_q == CNT_LAST) && !lock;
`else
    assign burst_done = (cnt_q == CNT_LAST);
`endif

    assign release_grant = !req[s16_q] || burst_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            cnt_q   <= '0;
            s16_q   <= 4'd0;
            gnt_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            s16_q   <= s16_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = GRANT;
            GRANT:   if (release_grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every release passes through IDLE for one cycle so the mux select settles.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        s16_d   = s16_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                gnt_d   = 16'h0000;
                valid_d = 1'b0;
                if (any_req) begin
                    s16_d   = winner;
                    gnt_d   = 16'h0001 << winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    gnt_d   = 16'h0000;
                    valid_d = 1'b0;
                    ptr_d   = s16_q + 4'd1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = 16'h0000;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign S16   = s16_q;
    assign gnt   = gnt_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: per-cycle vector table, generated round-robin sweep,
// and (with MUX16_ARB_LOCK_EN) a lock hold/release sequence.
module tb_mux16_rr_arbiter;

    localparam int BURST = 4;
    localparam int NVEC  = 35;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0000;
`ifdef MUX16_ARB_LOCK_EN
    logic        lock = 1'b0;
`endif
    logic [3:0]  S16;
    logic [15:0] gnt;
    logic        valid;

    mux16_rr_arbiter #(.BURST(BURST), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
`ifdef MUX16_ARB_LOCK_EN
        .lock  (lock),
`endif
        .S16   (S16),
        .gnt   (gnt),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [15:0] rq;
        logic [3:0]  s;
        logic [15:0] g;
        logic        v;
    } vec_t;

    typedef struct {
        logic [3:0]  s;
        logic [15:0] g;
        logic        v;
    } exp_t;

    vec_t tbl [NVEC];
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    task automatic step(input logic r, input logic [15:0] rq, input logic lk,
                        input logic [3:0] s, input logic [15:0] g, input logic v,
                        input string tag);
        exp_t e;
        rst = r;
        req = rq;
`ifdef MUX16_ARB_LOCK_EN
        lock = lk;
`else
        if (lk) begin end
`endif
        e.s = s;
        e.g = g;
        e.v = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (S16 !== e.s || gnt !== e.g || valid !== e.v) begin
            errors++;
            $display("FAIL %s: got S16=%0d gnt=%h valid=%b, expected S16=%0d gnt=%h valid=%b",
                     tag, S16, gnt, valid, e.s, e.g, e.v);
        end
    endtask

    initial begin
        // reset with all requests, then reset mid-grant
        tbl[0]  = '{1'b1, 16'hFFFF, 4'd0,  16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 16'hFFFF, 4'd0,  16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 16'hFFFF, 4'd0,  16'h0001, 1'b1};
        tbl[3]  = '{1'b1, 16'h0008, 4'd0,  16'h0000, 1'b0};
        // single requester 3: 4 on / 1 off
        tbl[4]  = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[5]  = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[6]  = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[7]  = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[8]  = '{1'b0, 16'h0008, 4'd3,  16'h0000, 1'b0};
        tbl[9]  = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[10] = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[11] = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[12] = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[13] = '{1'b0, 16'h0008, 4'd3,  16'h0000, 1'b0};
        tbl[14] = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        tbl[15] = '{1'b0, 16'h0008, 4'd3,  16'h0008, 1'b1};
        // early release of 3, then requester 5 for two cycles only
        tbl[16] = '{1'b0, 16'h0020, 4'd3,  16'h0000, 1'b0};
        tbl[17] = '{1'b0, 16'h0020, 4'd5,  16'h0020, 1'b1};
        tbl[18] = '{1'b0, 16'h0020, 4'd5,  16'h0020, 1'b1};
        tbl[19] = '{1'b0, 16'h0000, 4'd5,  16'h0000, 1'b0};
        tbl[20] = '{1'b0, 16'hFFFF, 4'd6,  16'h0040, 1'b1};
        // bring ptr to 9, then 0x0101 -> 0 then 8
        tbl[21] = '{1'b0, 16'h0100, 4'd6,  16'h0000, 1'b0};
        tbl[22] = '{1'b0, 16'h0100, 4'd8,  16'h0100, 1'b1};
        tbl[23] = '{1'b0, 16'h0000, 4'd8,  16'h0000, 1'b0};
        tbl[24] = '{1'b0, 16'h0101, 4'd0,  16'h0001, 1'b1};
        tbl[25] = '{1'b0, 16'h0100, 4'd0,  16'h0000, 1'b0};
        tbl[26] = '{1'b0, 16'h0100, 4'd8,  16'h0100, 1'b1};
        // bring ptr to 15 via grant 14, then 0x8001 -> 15 then 0
        tbl[27] = '{1'b0, 16'h4000, 4'd8,  16'h0000, 1'b0};
        tbl[28] = '{1'b0, 16'h4000, 4'd14, 16'h4000, 1'b1};
        tbl[29] = '{1'b0, 16'h8001, 4'd14, 16'h0000, 1'b0};
        tbl[30] = '{1'b0, 16'h8001, 4'd15, 16'h8000, 1'b1};
        tbl[31] = '{1'b0, 16'h0001, 4'd15, 16'h0000, 1'b0};
        tbl[32] = '{1'b0, 16'h0001, 4'd0,  16'h0001, 1'b1};
        tbl[33] = '{1'b0, 16'h0000, 4'd0,  16'h0000, 1'b0};
        tbl[34] = '{1'b0, 16'h0000, 4'd0,  16'h0000, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].r, tbl[i].rq, 1'b0, tbl[i].s, tbl[i].g, tbl[i].v,
                 $sformatf("vec%0d", i));
        end

        // full round robin with wrap 15 -> 0
        step(1'b1, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b0, "rr_reset");
        for (int g = 0; g <= 16; g++) begin
            for (int c = 0; c < BURST; c++) begin
                step(1'b0, 16'hFFFF, 1'b0, 4'(g % 16), 16'h0001 << (g % 16), 1'b1,
                     $sformatf("rr_grant%0d_c%0d", g, c));
            end
            step(1'b0, 16'hFFFF, 1'b0, 4'(g % 16), 16'h0000, 1'b0,
                 $sformatf("rr_gap%0d", g));
        end

`ifdef MUX16_ARB_LOCK_EN
        step(1'b1, 16'h0004, 1'b1, 4'd0, 16'h0000, 1'b0, "lock_reset");
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 16'h0004, 1'b1, 4'd2, 16'h0004, 1'b1, $sformatf("lock_hold%0d", c));
        end
        step(1'b0, 16'h0004, 1'b0, 4'd2, 16'h0000, 1'b0, "lock_release");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
